// File: rtl/kbd_pkg.sv
// Shared types and keycode constants for the two-player keyboard arbiter.
// Keycodes are the decoder's 9-bit {extend, scancode} form.
package kbd_pkg;

  typedef enum logic [2:0] {
    ACT_UP    = 3'd0,
    ACT_LEFT  = 3'd1,
    ACT_RIGHT = 3'd2,
    ACT_DOWN  = 3'd3,
    ACT_SMASH = 3'd4
  } action_e;

  localparam logic [8:0] KEY_P1_UP    = 9'h01D;
  localparam logic [8:0] KEY_P1_LEFT  = 9'h01C;
  localparam logic [8:0] KEY_P1_RIGHT = 9'h023;
  localparam logic [8:0] KEY_P1_DOWN  = 9'h01B;
  localparam logic [8:0] KEY_P1_SMASH = 9'h02B;
  localparam logic [8:0] KEY_P2_UP    = 9'h175;
  localparam logic [8:0] KEY_P2_LEFT  = 9'h16B;
  localparam logic [8:0] KEY_P2_RIGHT = 9'h174;
  localparam logic [8:0] KEY_P2_DOWN  = 9'h172;
  localparam logic [8:0] KEY_P2_SMASH = 9'h05A;

  // FIFO entry (4 bits) and full output command
  typedef struct packed {
    logic    press;
    action_e action;
  } entry_t;

  typedef struct packed {
    logic    player;
    logic    press;
    action_e action;
  } cmd_t;

endpackage

// File: rtl/evt_fifo.sv
// Small synchronous FIFO holding one player's key events.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module evt_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/ps2_key_arbiter.sv
// Maps PS/2 key events to per-player actions, queues them per player and
// round-robins the two queues onto one valid/ready command port.
module ps2_key_arbiter
  import kbd_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_valid,
  input  logic [8:0]   last_change,
  input  logic [511:0] key_down,
  output logic         cmd_valid,
  input  logic         cmd_ready,
  output logic         cmd_player,
  output logic [2:0]   cmd_action,
  output logic         cmd_press,
  output logic [4:0]   p1_hold,
  output logic [4:0]   p2_hold,
  output logic         p1_ovf,
  output logic         p2_ovf
);

  typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_e;

  state_e  state;
  logic    mapped;
  logic    evt_player;
  action_e evt_action;
  logic    press;
  logic    evt;
  logic    push1, push2, pop1, pop2;
  logic    full1, full2, empty1, empty2;
  entry_t  wentry, head1, head2, sel;
  logic    last;
  logic    grant;
  logic    load;

  always_comb begin
    mapped     = 1'b1;
    evt_player = 1'b0;
    evt_action = ACT_UP;
    case (last_change)
      KEY_P1_UP:    evt_action = ACT_UP;
      KEY_P1_LEFT:  evt_action = ACT_LEFT;
      KEY_P1_RIGHT: evt_action = ACT_RIGHT;
      KEY_P1_DOWN:  evt_action = ACT_DOWN;
      KEY_P1_SMASH: evt_action = ACT_SMASH;
      KEY_P2_UP:    begin evt_player = 1'b1; evt_action = ACT_UP;    end
      KEY_P2_LEFT:  begin evt_player = 1'b1; evt_action = ACT_LEFT;  end
      KEY_P2_RIGHT: begin evt_player = 1'b1; evt_action = ACT_RIGHT; end
      KEY_P2_DOWN:  begin evt_player = 1'b1; evt_action = ACT_DOWN;  end
      KEY_P2_SMASH: begin evt_player = 1'b1; evt_action = ACT_SMASH; end
      default:      mapped = 1'b0;
    endcase
  end

  // The decoder updates key_down in the same cycle as key_valid
  assign press  = key_down[last_change];
  assign evt    = key_valid & mapped;
  assign push1  = evt & ~evt_player;
  assign push2  = evt & evt_player;
  assign wentry = '{press: press, action: evt_action};

  evt_fifo #(.DEPTH(DEPTH), .WIDTH(4)) u_fifo_p1 (
    .clk(clk), .rst_n(rst_n), .push(push1), .wdata(wentry),
    .pop(pop1), .rdata(head1), .full(full1), .empty(empty1)
  );

  evt_fifo #(.DEPTH(DEPTH), .WIDTH(4)) u_fifo_p2 (
    .clk(clk), .rst_n(rst_n), .push(push2), .wdata(wentry),
    .pop(pop2), .rdata(head2), .full(full2), .empty(empty2)
  );

  always_comb begin
    if (!empty1 && !empty2) grant = ~last;
    else                    grant = ~empty2;
  end

  // Output register reloads whenever it is empty or being consumed
  assign load = ((state == S_EMPTY) | cmd_ready) & (~empty1 | ~empty2);
  assign pop1 = load & ~grant;
  assign pop2 = load & grant;
  assign sel  = grant ? head2 : head1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_hold <= '0;
      p2_hold <= '0;
      p1_ovf  <= 1'b0;
      p2_ovf  <= 1'b0;
    end else begin
      if (push1) p1_hold[evt_action] <= press;
      if (push2) p2_hold[evt_action] <= press;
      if (push1 && full1 && !pop1) p1_ovf <= 1'b1;
      if (push2 && full2 && !pop2) p2_ovf <= 1'b1;
    end
  end

  // state   | meaning
  // S_EMPTY | output register holds nothing, cmd_valid low
  // S_FULL  | command presented, held stable until cmd_ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_EMPTY;
      cmd_valid  <= 1'b0;
      cmd_player <= 1'b0;
      cmd_action <= 3'd0;
      cmd_press  <= 1'b0;
      last       <= 1'b1;
    end else begin
      case (state)
        S_EMPTY: begin
          if (load) begin
            state      <= S_FULL;
            cmd_valid  <= 1'b1;
            cmd_player <= grant;
            cmd_action <= sel.action;
            cmd_press  <= sel.press;
            last       <= grant;
          end
        end
        S_FULL: begin
          if (cmd_ready) begin
            if (load) begin
              cmd_player <= grant;
              cmd_action <= sel.action;
              cmd_press  <= sel.press;
              last       <= grant;
            end else begin
              state     <= S_EMPTY;
              cmd_valid <= 1'b0;
            end
          end
        end
        default: begin
          state     <= S_EMPTY;
          cmd_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_key_arbiter.sv
// Directed bench for ps2_key_arbiter: mapping, latency, arbitration,
// overflow, same-cycle push/pop on a full FIFO and async reset.
module tb_ps2_key_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         key_valid;
  logic [8:0]   last_change;
  logic [511:0] key_down;
  logic         cmd_valid;
  logic         cmd_ready;
  logic         cmd_player;
  logic [2:0]   cmd_action;
  logic         cmd_press;
  logic [4:0]   p1_hold;
  logic [4:0]   p2_hold;
  logic         p1_ovf;
  logic         p2_ovf;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ps2_key_arbiter #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .last_change(last_change),
    .key_down(key_down), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_player(cmd_player), .cmd_action(cmd_action), .cmd_press(cmd_press),
    .p1_hold(p1_hold), .p2_hold(p2_hold), .p1_ovf(p1_ovf), .p2_ovf(p2_ovf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cmd(input string tag, input logic v, input logic pl,
                         input logic [2:0] act, input logic pr);
    chk({tag, ".valid"},  {31'd0, cmd_valid},  {31'd0, v});
    chk({tag, ".player"}, {31'd0, cmd_player}, {31'd0, pl});
    chk({tag, ".action"}, {29'd0, cmd_action}, {29'd0, act});
    chk({tag, ".press"},  {31'd0, cmd_press},  {31'd0, pr});
  endtask

  // One decoder event: drive for one clock, then drop key_valid
  task automatic send(input logic [8:0] code, input logic pr);
    last_change    = code;
    key_down[code] = pr;
    key_valid      = 1'b1;
    tick();
    key_valid = 1'b0;
  endtask

  logic       p2_press [6];
  logic [2:0] p1_act   [6];
  logic       p1_pr    [6];
  logic [8:0] p1_code  [6];

  initial begin
    rst_n       = 1'b0;
    key_valid   = 1'b0;
    last_change = 9'd0;
    key_down    = '0;
    cmd_ready   = 1'b0;
    tick();
    tick();
    chk_cmd("reset", 1'b0, 1'b0, 3'd0, 1'b0);
    chk("reset.p1_hold", {27'd0, p1_hold}, 32'd0);
    chk("reset.p2_hold", {27'd0, p2_hold}, 32'd0);
    chk("reset.ovf", {30'd0, p1_ovf, p2_ovf}, 32'd0);
    rst_n = 1'b1;
    tick();

    // W make: hold at N+1, command at N+2
    send(9'h01D, 1'b1);
    chk("w.hold_n1", {27'd0, p1_hold}, 32'h01);
    chk("w.valid_n1", {31'd0, cmd_valid}, 32'd0);
    tick();
    chk_cmd("w.n2", 1'b1, 1'b0, 3'd0, 1'b1);
    cmd_ready = 1'b1;
    tick();
    chk("w.drained", {31'd0, cmd_valid}, 32'd0);

    // P1 A at N, P2 LEFT at N+1, ready held: back-to-back output
    last_change = 9'h01C; key_down[9'h01C] = 1'b1; key_valid = 1'b1;
    tick();
    last_change = 9'h16B; key_down[9'h16B] = 1'b1;
    tick();
    key_valid = 1'b0;
    chk_cmd("b2b.p1", 1'b1, 1'b0, 3'd1, 1'b1);
    tick();
    chk_cmd("b2b.p2", 1'b1, 1'b1, 3'd1, 1'b1);
    tick();
    chk("b2b.done", {31'd0, cmd_valid}, 32'd0);
    chk("b2b.p1_hold", {27'd0, p1_hold}, 32'h03);
    chk("b2b.p2_hold", {27'd0, p2_hold}, 32'h02);

    // Overflow: occupy the output with P1 DOWN, then six P2 RIGHT events
    cmd_ready = 1'b0;
    send(9'h01B, 1'b1);
    tick();
    chk_cmd("ovf.pre", 1'b1, 1'b0, 3'd3, 1'b1);
    p2_press = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      send(9'h174, p2_press[i]);
      chk($sformatf("ovf.hold%0d", i), {31'd0, p2_hold[2]}, {31'd0, p2_press[i]});
    end
    chk("ovf.p2_ovf", {31'd0, p2_ovf}, 32'd1);
    chk("ovf.p1_ovf", {31'd0, p1_ovf}, 32'd0);
    chk_cmd("ovf.stable", 1'b1, 1'b0, 3'd3, 1'b1);
    cmd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_cmd($sformatf("ovf.cmd%0d", i), 1'b1, 1'b1, 3'd2, p2_press[i]);
    end
    tick();
    chk("ovf.exact4", {31'd0, cmd_valid}, 32'd0);
    chk("ovf.p1_hold", {27'd0, p1_hold}, 32'h0B);

    // Unmapped space key
    send(9'h029, 1'b1);
    chk("unmapped.p1_hold", {27'd0, p1_hold}, 32'h0B);
    chk("unmapped.p2_hold", {27'd0, p2_hold}, 32'h06);
    tick();
    chk("unmapped.valid", {31'd0, cmd_valid}, 32'd0);
    tick();
    chk("unmapped.valid2", {31'd0, cmd_valid}, 32'd0);

    // Fill P1 (one in output + four queued), then push while popping
    cmd_ready = 1'b0;
    p1_code = '{9'h01D, 9'h01C, 9'h023, 9'h01B, 9'h02B, 9'h023};
    p1_act  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd2};
    p1_pr   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) send(p1_code[i], p1_pr[i]);
    chk_cmd("full.e0", 1'b1, 1'b0, p1_act[0], p1_pr[0]);
    chk("full.ovf_before", {31'd0, p1_ovf}, 32'd0);
    cmd_ready = 1'b1;
    send(p1_code[5], p1_pr[5]);
    chk("full.ovf_after", {31'd0, p1_ovf}, 32'd0);
    for (int i = 1; i < 6; i++) begin
      chk_cmd($sformatf("full.e%0d", i), 1'b1, 1'b0, p1_act[i], p1_pr[i]);
      tick();
    end
    chk("full.done", {31'd0, cmd_valid}, 32'd0);
    chk("full.p1_hold", {27'd0, p1_hold}, 32'h10);

    // Round-robin tie: P2 in output, P1 and P2 both queued -> P1 first
    cmd_ready = 1'b0;
    send(9'h175, 1'b1);
    send(9'h02B, 1'b0);
    send(9'h172, 1'b1);
    chk_cmd("rr.head", 1'b1, 1'b1, 3'd0, 1'b1);
    cmd_ready = 1'b1;
    tick();
    chk_cmd("rr.p1", 1'b1, 1'b0, 3'd4, 1'b0);
    tick();
    chk_cmd("rr.p2", 1'b1, 1'b1, 3'd3, 1'b1);
    tick();
    chk("rr.done", {31'd0, cmd_valid}, 32'd0);

    // Async reset with a presented command and queued entries
    cmd_ready = 1'b0;
    send(9'h175, 1'b1);
    send(9'h16B, 1'b1);
    send(9'h172, 1'b0);
    chk("rst.pre_valid", {31'd0, cmd_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_cmd("rst.async", 1'b0, 1'b0, 3'd0, 1'b0);
    chk("rst.holds", {22'd0, p1_hold, p2_hold}, 32'd0);
    chk("rst.ovf", {30'd0, p1_ovf, p2_ovf}, 32'd0);
    tick();
    rst_n = 1'b1;
    cmd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("rst.nostale%0d", i), {31'd0, cmd_valid}, 32'd0);
    end

    // Fresh event after reset still works
    send(9'h05A, 1'b1);
    tick();
    chk_cmd("post_rst", 1'b1, 1'b1, 3'd4, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_key_arbiter.md
# ps2_key_arbiter

Maps decoded keyboard events onto per-player game actions for the two-player volleyball game. Each player gets a small event FIFO, and the block arbitrates round-robin between the two FIFOs onto a single valid/ready command port feeding the game-logic FSM. It sits directly downstream of the PS/2 keyboard decoder (`key_valid`, `last_change`, `key_down`). It also provides registered per-player "held" action vectors for continuous movement.

## Interface
Parameters:
- `DEPTH`, 4: entries per player FIFO; power of two, minimum 2.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `key_valid`  in  1  one-cycle pulse from the decoder; a make or break event occurred.
- `last_change`  in  9  `{extend, scancode[7:0]}` of the event.
- `key_down`  in  512  decoder key-state vector; it is already updated in the same cycle as `key_valid`.
- `cmd_valid`  out  1  output command available.
- `cmd_ready`  in  1  consumer accepts the command when `cmd_valid & cmd_ready`.
- `cmd_player`  out  1  0 = P1, 1 = P2.
- `cmd_action`  out  3  0 UP, 1 LEFT, 2 RIGHT, 3 DOWN, 4 SMASH.
- `cmd_press`  out  1  1 = make, 0 = break.
- `p1_hold`, `p2_hold`  out  5 each  bit[action] = key currently held.
- `p1_ovf`, `p2_ovf`  out  1 each  sticky FIFO-overflow flag; cleared only by reset.

## Operation
- Key map (9-bit codes):
  - P1: UP 0x01D (W), LEFT 0x01C (A), RIGHT 0x023 (D), DOWN 0x01B (S), SMASH 0x02B (F).
  - P2: UP 0x175, LEFT 0x16B, RIGHT 0x174, DOWN 0x172, SMASH 0x05A (Enter).
  - All other codes are ignored: no enqueue, no hold change.
- Event capture: on `key_valid` with a mapped code:
  - press = `key_down[last_change]`.
  - Entry `{press, action}` is written to the owning player's FIFO.
  - The hold bit for that action is set to press.
- FIFO full:
  - Event dropped; the player's `ovf` flag is set; the hold bit still updates.
  - Exception: if that FIFO is popped in the same cycle, the event is accepted.
- Output stage: one register, FSM with two states.
  - EMPTY: if either FIFO is non-empty, pop the selected FIFO into the output register and move to FULL.
  - FULL: `cmd_valid` = 1; outputs are stable until the handshake.
  - On handshake: if a FIFO is non-empty, reload the same cycle and stay FULL (back-to-back throughput 1/cycle); otherwise go to EMPTY.
- Arbitration:
  - Round-robin with a `last` pointer.
  - If both FIFOs are non-empty, grant the player ≠ `last`. Otherwise grant whichever is non-empty.
  - `last` updates on every pop.
- Order within a player is strictly FIFO.

## Timing
- Reset values: `cmd_valid` 0, `cmd_player`/`cmd_action`/`cmd_press` 0, holds 0, ovf 0, FIFOs empty, `last` = 1 (so P1 wins the first tie).
- Latency: `key_valid` at cycle N → entry in FIFO at N+1 → `cmd_valid` at N+2 when the output stage is empty and this player is granted.
- Hold vectors update at N+1.
- Reset asserted mid-operation clears everything immediately; FIFO contents are discarded.
- `cmd_valid` never drops without a handshake.

## Structure
- Shared package `kbd_pkg`:
  - action enum (`ACT_UP`..`ACT_SMASH`).
  - the ten 9-bit keycode constants.
  - command struct `{player, press, action}`.
- One sub-module `evt_fifo` (parameterized `DEPTH`, width 4, push/pop/full/empty), instantiated twice.
- Key map, hold registers, arbiter and output FSM are inline.

## Test plan
- Reset, then key_valid with 0x01D and `key_down[0x01D]`=1 → at N+2: `cmd_valid`, player 0, action 0, press 1; `p1_hold` = 5'b00001 from N+1.
- P1 0x01C make at cycle N, P2 0x16B make at N+1, `cmd_ready` held 1 → outputs P1 LEFT, then P2 LEFT, on consecutive cycles.
- `cmd_ready`=0; six P2 0x174 events → four queued, `p2_ovf`=1; releasing ready yields exactly four commands, `p2_hold[2]` tracks the last press value.
- Unmapped 0x029 (space) make → no `cmd_valid`, holds unchanged.
- P1 full and popped in the same cycle as a new P1 event → event accepted, `p1_ovf` stays 0.
- `rst_n` low while `cmd_valid`=1 with queued entries → all outputs 0 asynchronously; after release, no stale commands appear.
